// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - shared state encoding and geometry defaults for falling-block control
package block_pkg;

  localparam int BLOCK_SIZE_DEF  = 16;
  localparam int PLAYER_SIZE_DEF = 16;
  localparam int SCREEN_H_DEF    = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FALL,
    ST_HIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - synchronizes frame_clk into Clk and emits a one-cycle pulse per rising edge
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] warm_q;

  // warm_q holds off the edge detector until prev_q carries a real sample,
  // so a frame_clk already high at reset release is not mistaken for an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 3'b000;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[1:0], 1'b1};
    end
  end

  assign frame_tick = warm_q[2] & sync2_q & ~prev_q;

endmodule

// File: rtl/block_motion_ctrl.sv
// rtl/block_motion_ctrl.sv - falling-block motion FSM with player collision and level-end detection
module block_motion_ctrl
  import block_pkg::*;
#(
  parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF,
  parameter int PLAYER_SIZE = PLAYER_SIZE_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       block_ready,
  input  logic [9:0] spawn_x,
  input  logic [3:0] fall_step,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] block_x,
  output logic [9:0] block_y,
  output logic       block_visible,
  output logic       collision,
  output logic       end_level
);

  state_e      state_q, state_d;
  logic [9:0]  bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  logic [3:0]  step_q, step_d;
  logic        coll_q, coll_d;
  logic        frame_tick;
  logic        overlap;
  logic [10:0] next_y;

  frame_tick_gen u_frame_tick_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  // 11-bit sums so edges near 1023 never wrap into a false overlap.
  assign overlap = ({1'b0, bx_q} < ({1'b0, player_x} + 11'(PLAYER_SIZE))) &&
                   ({1'b0, player_x} < ({1'b0, bx_q} + 11'(BLOCK_SIZE))) &&
                   ({1'b0, by_q} < ({1'b0, player_y} + 11'(PLAYER_SIZE))) &&
                   ({1'b0, player_y} < ({1'b0, by_q} + 11'(BLOCK_SIZE)));

  assign next_y = {1'b0, by_q} + {7'b0, step_q};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      step_q  <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      step_q  <= step_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    step_d  = step_q;
    coll_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (block_ready) begin
          state_d = ST_FALL;
          bx_d    = spawn_x;
          by_d    = '0;
          step_d  = fall_step;
        end
      end
      ST_FALL: begin
        if (!block_ready) begin
          state_d = ST_IDLE;
          bx_d    = '0;
          by_d    = '0;
        end else if (overlap) begin
          state_d = ST_HIT;
          coll_d  = 1'b1;
        end else if (frame_tick) begin
          if (next_y > 11'(SCREEN_H - BLOCK_SIZE)) begin
            state_d = ST_DONE;
          end else begin
            by_d = next_y[9:0];
          end
        end
      end
      ST_HIT, ST_DONE: begin
        if (!block_ready) begin
          state_d = ST_IDLE;
          bx_d    = '0;
          by_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign block_x       = bx_q;
  assign block_y       = by_q;
  assign block_visible = (state_q == ST_FALL);
  assign collision     = coll_q;
  assign end_level     = (state_q == ST_DONE);

endmodule

// File: tb/tb_block_motion_ctrl.sv
// tb/tb_block_motion_ctrl.sv - directed self-checking bench for block_motion_ctrl
module tb_block_motion_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       block_ready;
  logic [9:0] spawn_x;
  logic [3:0] fall_step;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [9:0] block_x;
  logic [9:0] block_y;
  logic       block_visible;
  logic       collision;
  logic       end_level;

  int vectors = 0;
  int errors  = 0;

  block_motion_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .block_ready  (block_ready),
    .spawn_x      (spawn_x),
    .fall_step    (fall_step),
    .player_x     (player_x),
    .player_y     (player_y),
    .block_x      (block_x),
    .block_y      (block_y),
    .block_visible(block_visible),
    .collision    (collision),
    .end_level    (end_level)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int x, input int y,
                            input int v, input int c, input int e);
    check({tag, "_x"}, int'(block_x), x);
    check({tag, "_y"}, int'(block_y), y);
    check({tag, "_vis"}, int'(block_visible), v);
    check({tag, "_col"}, int'(collision), c);
    check({tag, "_end"}, int'(end_level), e);
  endtask

  task automatic spawn(input int x, input int step);
    spawn_x     = 10'(x);
    fall_step   = 4'(step);
    block_ready = 1'b1;
    cyc();
  endtask

  // Two low cycles, then a rising edge; returns right after the resulting advance.
  task automatic frame();
    repeat (2) cyc();
    frame_clk = 1'b1;
    repeat (3) cyc();
    frame_clk = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    block_ready = 1'b0;
    spawn_x     = 10'd0;
    fall_step   = 4'd0;
    player_x    = 10'd400;
    player_y    = 10'd0;
    repeat (3) cyc();
    check_outs("reset", 0, 0, 0, 0, 0);
    Reset = 1'b0;
    repeat (4) cyc();
    check_outs("idle", 0, 0, 0, 0, 0);

    // Fall to the bottom of the screen
    spawn(100, 4);
    check_outs("spawn", 100, 0, 1, 0, 0);
    spawn_x   = 10'd300;
    fall_step = 4'd9;
    frame();
    check_outs("tick1", 100, 4, 1, 0, 0);
    repeat (115) frame();
    check_outs("tick116", 100, 464, 1, 0, 0);
    frame();
    check_outs("tick117", 100, 464, 0, 0, 1);
    repeat (3) cyc();
    check_outs("done_hold", 100, 464, 0, 0, 1);
    block_ready = 1'b0;
    cyc();
    check_outs("done_exit", 0, 0, 0, 0, 0);

    // Collision after 24 ticks of 8 pixels
    player_x = 10'd100;
    player_y = 10'd200;
    spawn(100, 8);
    repeat (24) frame();
    check_outs("hit_pre", 100, 192, 1, 0, 0);
    cyc();
    check_outs("hit_first", 100, 192, 0, 1, 0);
    cyc();
    check_outs("hit_second", 100, 192, 0, 0, 0);
    block_ready = 1'b0;
    cyc();
    check_outs("hit_exit", 0, 0, 0, 0, 0);

    // Abort mid-fall; IDLE ignores ticks and spawn inputs
    player_x = 10'd400;
    player_y = 10'd0;
    spawn(100, 4);
    repeat (10) frame();
    check_outs("abort_pre", 100, 40, 1, 0, 0);
    block_ready = 1'b0;
    cyc();
    check_outs("abort", 0, 0, 0, 0, 0);
    spawn_x   = 10'd55;
    fall_step = 4'd7;
    repeat (3) frame();
    check_outs("idle_ticks", 0, 0, 0, 0, 0);

    // Overlap arriving in the same cycle as a frame tick
    spawn(100, 4);
    repeat (5) frame();
    check_outs("same_pre", 100, 20, 1, 0, 0);
    repeat (2) cyc();
    frame_clk = 1'b1;
    cyc();
    cyc();
    player_x = 10'd100;
    player_y = 10'd20;
    cyc();
    check_outs("same_hit", 100, 20, 0, 1, 0);
    frame_clk   = 1'b0;
    block_ready = 1'b0;
    cyc();
    check_outs("same_exit", 0, 0, 0, 0, 0);

    // Zero step stays put; block_ready low outranks overlap
    player_x = 10'd400;
    player_y = 10'd0;
    spawn(100, 0);
    repeat (3) frame();
    check_outs("step0", 100, 0, 1, 0, 0);
    player_x    = 10'd100;
    block_ready = 1'b0;
    cyc();
    check_outs("prio", 0, 0, 0, 0, 0);
    player_x = 10'd400;
    spawn(100, 0);
    player_x = 10'd110;
    player_y = 10'd10;
    cyc();
    check_outs("step0_hit", 100, 0, 0, 1, 0);
    block_ready = 1'b0;
    player_x    = 10'd400;
    player_y    = 10'd0;
    cyc();

    // Edge-touching boxes do not overlap
    player_x = 10'd116;
    spawn(100, 0);
    cyc();
    check_outs("touch_x", 100, 0, 1, 0, 0);
    block_ready = 1'b0;
    player_x    = 10'd400;
    cyc();

    // Asynchronous reset mid-fall with frame_clk held high through release
    spawn(100, 8);
    repeat (10) frame();
    check_outs("rst_pre", 100, 80, 1, 0, 0);
    frame_clk = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0, 0);
    repeat (2) cyc();
    Reset = 1'b0;
    repeat (8) cyc();
    check_outs("rst_high", 100, 0, 1, 0, 0);
    frame_clk = 1'b0;
    frame();
    check_outs("rst_tick", 100, 8, 1, 0, 0);

    // Long high level produces a single advance
    repeat (2) cyc();
    frame_clk = 1'b1;
    repeat (1000) cyc();
    check_outs("long_high", 100, 16, 1, 0, 0);
    frame_clk = 1'b0;
    frame();
    check_outs("after_long", 100, 24, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
